// File: rtl/soc_system_v5_ctrl_out_pkg.sv
// soc_system_v5_ctrl_out_pkg: shared constants and types for the control output PIO.
// The register address map, the writedata/readdata bit positions and the pulse timer state encoding.
package soc_system_v5_ctrl_out_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLEAR = 2'd2;
    localparam logic [1:0] ADDR_PULSE = 2'd3;

    localparam int PULSE_LEN_LSB = 16;
    localparam int BUSY_BIT      = 31;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } timer_state_e;

endpackage

// File: rtl/soc_system_v5_pulse_timer.sv
// soc_system_v5_pulse_timer: one-shot pulse timer that holds a mask active for an exact number of clk cycles.
// Ports: clk, reset_n (sync, active-low); load/mask/len start or retrigger a pulse (len=0 is ignored);
// busy high while the pulse runs, mask_q the latched mask, count the cycles remaining, done a one-cycle end strobe.
module soc_system_v5_pulse_timer
    import soc_system_v5_ctrl_out_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [CNT_WIDTH-1:0]  len,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mask_q,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  done
);

    timer_state_e state, state_next;
    logic start;
    logic last;

    assign start = load && (len != '0);
    assign last  = (state == ACTIVE) && (count == CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            mask_q <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            // A reload on the final cycle wins, so a retriggered pulse never reports done.
            done  <= last && !start;
            if (start) begin
                mask_q <= mask;
                count  <= len;
            end else if (state == ACTIVE) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = start ? ACTIVE : (last ? IDLE : state);
    end

    always_comb begin
        busy = (state == ACTIVE);
    end

endmodule

// File: rtl/soc_system_v5_ctrl_out_pulse.sv
// soc_system_v5_ctrl_out_pulse: Avalon-MM control output PIO with level/set/clear writes and a timed pulse.
// Ports: clk, reset_n (sync, active-low); address/chipselect/write_n/writedata Avalon slave write side;
// readdata registered read data (latency 1); out_port output lines; pulse_busy/pulse_done pulse timer status.
module soc_system_v5_ctrl_out_pulse
    import soc_system_v5_ctrl_out_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy,
    output logic                  pulse_done
);

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [CNT_WIDTH-1:0]  count;
    logic [31:0]           status;
    logic [31:0]           rd_mux;
    logic                  unused_writedata;

    assign wr = chipselect && !write_n;
    assign wd = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;

    soc_system_v5_pulse_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (wr && (address == ADDR_PULSE)),
        .mask   (wd),
        .len    (writedata[PULSE_LEN_LSB +: CNT_WIDTH]),
        .busy   (pulse_busy),
        .mask_q (pulse_mask),
        .count  (count),
        .done   (pulse_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            data_reg <= (address == ADDR_DATA)  ? wd :
                        (address == ADDR_SET)   ? (data_reg | wd) :
                        (address == ADDR_CLEAR) ? (data_reg & ~wd) : data_reg;
        end
    end

    assign out_port = data_reg | (pulse_busy ? pulse_mask : '0);

    always_comb begin
        status = 32'(count);
        status[BUSY_BIT] = pulse_busy;
        rd_mux = (address == ADDR_DATA)  ? 32'(data_reg) :
                 (address == ADDR_SET)   ? 32'(out_port) :
                 (address == ADDR_CLEAR) ? 32'(pulse_mask) : status;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_v5_ctrl_out_pulse.sv
// tb_soc_system_v5_ctrl_out_pulse: directed self-checking bench for the control output PIO.
module tb_soc_system_v5_ctrl_out_pulse;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;
    logic        pulse_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    soc_system_v5_ctrl_out_pulse #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .pulse_busy(pulse_busy),
        .pulse_done(pulse_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #1;
        tick(); tick();
        chk("rst_out", 32'(out_port), 32'hA5);
        chk("rst_rd", readdata, 32'h0);
        chk("rst_busy", 32'(pulse_busy), 32'h0);
        chk("rst_done", 32'(pulse_done), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rd_addr0_reset", readdata, 32'h0000_00A5);

        wr(2'd0, 32'hFFFF_FF0F);
        chk("data_wr", 32'(out_port), 32'h0F);
        wr(2'd1, 32'h0000_0030);
        chk("set_wr", 32'(out_port), 32'h3F);
        wr(2'd2, 32'h0000_0003);
        chk("clear_wr", 32'(out_port), 32'h3C);
        address = 2'd0;
        tick();
        chk("rd_addr0", readdata, 32'h0000_003C);
        address = 2'd1;
        tick();
        chk("rd_addr1", readdata, 32'h0000_003C);

        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0005_0081);
        address = 2'd3;
        chk("p_out0", 32'(out_port), 32'h81);
        chk("p_busy0", 32'(pulse_busy), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("p_out", 32'(out_port), 32'h81);
            chk("p_rd", readdata, 32'h8000_0000 | 32'(6 - i));
            chk("p_done_lo", 32'(pulse_done), 32'h0);
        end
        tick();
        chk("p_out_end", 32'(out_port), 32'h00);
        chk("p_rd_last", readdata, 32'h8000_0001);
        chk("p_done", 32'(pulse_done), 32'h1);
        chk("p_busy_end", 32'(pulse_busy), 32'h0);
        tick();
        chk("p_done_off", 32'(pulse_done), 32'h0);
        chk("p_rd_idle", readdata, 32'h0);
        address = 2'd2;
        tick();
        chk("rd_mask", readdata, 32'h0000_0081);

        wr(2'd3, 32'h000A_0001);
        chk("rt_out0", 32'(out_port), 32'h01);
        tick(); tick(); tick();
        chk("rt_out3", 32'(out_port), 32'h01);
        wr(2'd3, 32'h0003_0002);
        chk("rt_reload", 32'(out_port), 32'h02);
        chk("rt_done0", 32'(pulse_done), 32'h0);
        tick();
        chk("rt_out1", 32'(out_port), 32'h02);
        chk("rt_done1", 32'(pulse_done), 32'h0);
        tick();
        chk("rt_out2", 32'(out_port), 32'h02);
        chk("rt_done2", 32'(pulse_done), 32'h0);
        tick();
        chk("rt_out_end", 32'(out_port), 32'h00);
        chk("rt_done", 32'(pulse_done), 32'h1);
        tick();
        chk("rt_done_off", 32'(pulse_done), 32'h0);
        wr(2'd3, 32'h0000_00FF);
        chk("l0_busy", 32'(pulse_busy), 32'h0);
        chk("l0_out", 32'(out_port), 32'h00);
        address = 2'd2;
        tick();
        chk("l0_mask", readdata, 32'h0000_0002);

        wr(2'd3, 32'h0004_0001);
        wr(2'd1, 32'h0000_0001);
        wr(2'd3, 32'h0000_0080);
        chk("set_mid_busy", 32'(pulse_busy), 32'h1);
        chk("set_mid_out", 32'(out_port), 32'h01);
        tick();
        tick();
        chk("set_end_busy", 32'(pulse_busy), 32'h0);
        chk("set_end_done", 32'(pulse_done), 32'h1);
        chk("set_end_out", 32'(out_port), 32'h01);

        wr(2'd3, 32'h0004_0001);
        wr(2'd2, 32'h0000_0001);
        chk("clr_mid_out", 32'(out_port), 32'h01);
        tick();
        tick();
        chk("clr_last_out", 32'(out_port), 32'h01);
        tick();
        chk("clr_end_out", 32'(out_port), 32'h00);
        chk("clr_end_done", 32'(pulse_done), 32'h1);

        wr(2'd3, 32'h000A_0040);
        tick(); tick(); tick();
        chk("rm_out", 32'(out_port), 32'h40);
        address = 2'd3;
        tick();
        chk("rm_count", readdata, 32'h8000_0007);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rm_busy", 32'(pulse_busy), 32'h0);
        chk("rm_out_rst", 32'(out_port), 32'hA5);
        chk("rm_done", 32'(pulse_done), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rm_no_done", 32'(pulse_done), 32'h0);
        end
        chk("rm_rd", readdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
